bcd_countdown_timer: RTL and testbench

Two-digit BCD countdown timer for the DE2 board display path. It counts down from a switch-loaded value (00–99) once per `novo_clock1` rising edge while running, then stops at 00 and raises `done`. The divided 1 Hz clock drives it, and it drives two seven-segment digits directly. It is the down-counting, preset-and-expire counterpart of the existing free-running BCD up counter.

---
 rtl/bcd_countdown_timer_pkg.sv | 48 ++++
 rtl/bcd_countdown_timer_if.sv | 25 ++
 rtl/bcd_countdown_timer_digit.sv | 40 ++++
 rtl/bcd_countdown_timer.sv | 106 ++++++++++
 tb/tb_bcd_countdown_timer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD timer/counter display path.
//   state_t     : timer FSM state encoding
//   BCD_MAX/ZERO: BCD digit limits
//   SEG_*       : active-high seven-segment glyphs, index 0 = segment a .. 6 = segment g
//   seg_decode  : BCD digit to active-high glyph; codes 10-15 blank
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  localparam logic [0:6] SEG_0     = 7'b1111110;
  localparam logic [0:6] SEG_1     = 7'b0110000;
  localparam logic [0:6] SEG_2     = 7'b1101101;
  localparam logic [0:6] SEG_3     = 7'b1111001;
  localparam logic [0:6] SEG_4     = 7'b0110011;
  localparam logic [0:6] SEG_5     = 7'b1011011;
  localparam logic [0:6] SEG_6     = 7'b1011111;
  localparam logic [0:6] SEG_7     = 7'b1110000;
  localparam logic [0:6] SEG_8     = 7'b1111111;
  localparam logic [0:6] SEG_9     = 7'b1111011;
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  function automatic logic [0:6] seg_decode(input logic [3:0] digit);
    logic [0:6] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle of the BCD countdown timer.
//   master: drives load_val/load/start/pause, observes count, display and status
//   slave : the timer itself
interface bcd_countdown_timer_if;
  logic [7:0] load_val;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] bcd_lo;
  logic [3:0] bcd_hi;
  logic [0:6] hex_lo;
  logic [0:6] hex_hi;
  logic       busy;
  logic       done;

  modport master (
    output load_val, load, start, pause,
    input  bcd_lo, bcd_hi, hex_lo, hex_hi, busy, done
  );

  modport slave (
    input  load_val, load, start, pause,
    output bcd_lo, bcd_hi, hex_lo, hex_hi, busy, done
  );
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit down-counter.
//   novo_clock1 : counting clock
//   reset       : asynchronous, active-low; digit -> 0
//   load        : copy load_digit (clamped to 9) into the digit; overrides counting
//   load_digit  : preset value
//   en          : count enable
//   borrow_in   : decrement request from the lower digit (tie high for the lowest)
//   digit       : current value
//   borrow_out  : this digit is 0 while a borrow is requested, i.e. it would wrap
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic       novo_clock1,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Not gated by en: the tens borrow_out doubles as the "count is 00" flag.
  assign borrow_out = borrow_in && (digit == BCD_ZERO);

  always_ff @(posedge novo_clock1 or negedge reset) begin
    if (!reset) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (en && borrow_in) begin
      digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with seven-segment outputs.
//   novo_clock1 : counting clock (divided 1 Hz)
//   reset       : asynchronous, active-low
//   bus         : slave side of bcd_countdown_timer_if
//                 load_val/load/start/pause in; bcd_lo/bcd_hi, hex_lo/hex_hi,
//                 busy (in RUN), done (in DONE) out
// Input priority on every edge: load > pause > start.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic               novo_clock1,
  input logic               reset,
  bcd_countdown_timer_if.slave bus
);

  state_t     state, state_nxt;
  logic [3:0] cnt_lo, cnt_hi;
  logic       borrow_lo;
  logic       cnt_zero;
  logic       cnt_one;
  logic       run_en;
  logic       busy_q, done_q;

  assign cnt_one = (cnt_hi == BCD_ZERO) && (cnt_lo == 4'd1);

  // Never decrement from 00, so the count cannot wrap to 99.
  assign run_en = (state == RUN) && !bus.load && !bus.pause && !cnt_zero;

  bcd_digit_down u_units (
    .novo_clock1 (novo_clock1),
    .reset       (reset),
    .load        (bus.load),
    .load_digit  (bus.load_val[3:0]),
    .en          (run_en),
    .borrow_in   (1'b1),
    .digit       (cnt_lo),
    .borrow_out  (borrow_lo)
  );

  // Tens decrements only when the units digit wraps 0 -> 9; its borrow-out
  // is therefore high exactly when both digits are 0.
  bcd_digit_down u_tens (
    .novo_clock1 (novo_clock1),
    .reset       (reset),
    .load        (bus.load),
    .load_digit  (bus.load_val[7:4]),
    .en          (run_en),
    .borrow_in   (borrow_lo),
    .digit       (cnt_hi),
    .borrow_out  (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.pause && bus.start) begin
            state_nxt = cnt_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_nxt = HOLD;
          end else if (cnt_one || cnt_zero) begin
            // This edge's decrement lands on 00.
            state_nxt = DONE;
          end
        end
        HOLD: begin
          if (!bus.pause && bus.start) begin
            state_nxt = RUN;
          end
        end
        DONE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status flags are registered decodes of the next state so they line up
  // with the state register.
  always_ff @(posedge novo_clock1 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.bcd_lo = cnt_lo;
  assign bus.bcd_hi = cnt_hi;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hex_lo = SEG_ACTIVE_LOW ? ~seg_decode(cnt_lo) : seg_decode(cnt_lo);
  assign bus.hex_hi = SEG_ACTIVE_LOW ? ~seg_decode(cnt_hi) : seg_decode(cnt_hi);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

  logic novo_clock1 = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .novo_clock1 (novo_clock1),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 novo_clock1 = ~novo_clock1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] count_now();
    return {bus.bcd_hi, bus.bcd_lo};
  endfunction

  task automatic step();
    @(posedge novo_clock1);
    #1;
  endtask

  logic [7:0] exp_cnt;

  initial begin
    reset        = 1'b1;
    bus.load_val = 8'h00;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_cnt",    count_now(), 8'h00);
    check("rst_busy",   {7'd0, bus.busy}, 8'd0);
    check("rst_done",   {7'd0, bus.done}, 8'd0);
    check("rst_hex_lo", {1'b0, bus.hex_lo}, 8'b0000_0001);
    check("rst_hex_hi", {1'b0, bus.hex_hi}, 8'b0000_0001);
    step();
    #2 reset = 1'b1;

    // Reset mid-run at 37
    bus.load_val = 8'h37; bus.load = 1'b1;
    step();
    bus.load = 1'b0; bus.start = 1'b1;
    step();
    check("run37_cnt",  count_now(), 8'h37);
    check("run37_busy", {7'd0, bus.busy}, 8'd1);
    reset = 1'b0;
    #2;
    check("midrst_cnt",    count_now(), 8'h00);
    check("midrst_busy",   {7'd0, bus.busy}, 8'd0);
    check("midrst_done",   {7'd0, bus.done}, 8'd0);
    check("midrst_hex_lo", {1'b0, bus.hex_lo}, 8'b0000_0001);
    check("midrst_hex_hi", {1'b0, bus.hex_hi}, 8'b0000_0001);
    reset = 1'b1;
    step();
    // First edge acts from IDLE with count 00 and start high
    check("postrst_done", {7'd0, bus.done}, 8'd1);
    check("postrst_busy", {7'd0, bus.busy}, 8'd0);

    // Borrow case: 20 -> 19 -> 18
    bus.load_val = 8'h20; bus.load = 1'b1; bus.start = 1'b0;
    step();
    check("ld20_cnt",  count_now(), 8'h20);
    check("ld20_done", {7'd0, bus.done}, 8'd0);
    bus.load = 1'b0; bus.start = 1'b1;
    step();
    check("run20_cnt",    count_now(), 8'h20);
    check("run20_hex_hi", {1'b0, bus.hex_hi}, 8'b0001_0010);
    check("run20_hex_lo", {1'b0, bus.hex_lo}, 8'b0000_0001);
    step();
    check("dec19_cnt",    count_now(), 8'h19);
    check("dec19_hex_hi", {1'b0, bus.hex_hi}, 8'b0100_1111);
    check("dec19_hex_lo", {1'b0, bus.hex_lo}, 8'b0000_0100);
    step();
    check("dec18_cnt",    count_now(), 8'h18);
    check("dec18_hex_lo", {1'b0, bus.hex_lo}, 8'b0000_0000);

    // Zero load
    bus.load_val = 8'h00; bus.load = 1'b1; bus.start = 1'b0;
    step();
    check("ld00_cnt",  count_now(), 8'h00);
    check("ld00_busy", {7'd0, bus.busy}, 8'd0);
    bus.load = 1'b0; bus.start = 1'b1;
    step();
    check("zero_done", {7'd0, bus.done}, 8'd1);
    check("zero_busy", {7'd0, bus.busy}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("zero_hold_cnt",  count_now(), 8'h00);
      check("zero_hold_busy", {7'd0, bus.busy}, 8'd0);
    end
    check("zero_hold_done", {7'd0, bus.done}, 8'd1);

    // Pause and resume
    bus.load_val = 8'h10; bus.load = 1'b1; bus.start = 1'b0;
    step();
    bus.load = 1'b0; bus.start = 1'b1;
    step();
    check("run10_cnt", count_now(), 8'h10);
    step(); step(); step();
    check("pre_pause_cnt", count_now(), 8'h07);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_cnt",  count_now(), 8'h07);
      check("hold_busy", {7'd0, bus.busy}, 8'd0);
    end
    bus.pause = 1'b0;
    step();
    check("resume_cnt",  count_now(), 8'h07);
    check("resume_busy", {7'd0, bus.busy}, 8'd1);
    step();
    check("resume_06", count_now(), 8'h06);
    for (int i = 0; i < 5; i++) step();
    check("resume_01",      count_now(), 8'h01);
    check("resume_01_done", {7'd0, bus.done}, 8'd0);
    step();
    check("resume_00",   count_now(), 8'h00);
    check("resume_done", {7'd0, bus.done}, 8'd1);
    check("resume_busy_end", {7'd0, bus.busy}, 8'd0);

    // Clamp and load-over-start priority
    bus.load_val = 8'hAF; bus.load = 1'b1; bus.start = 1'b1;
    step();
    check("clamp_cnt",  count_now(), 8'h99);
    check("clamp_busy", {7'd0, bus.busy}, 8'd0);
    check("clamp_done", {7'd0, bus.done}, 8'd0);
    bus.load = 1'b0;
    step();
    check("clamp_run_busy", {7'd0, bus.busy}, 8'd1);
    check("clamp_run_cnt",  count_now(), 8'h99);
    step();
    check("clamp_dec98", count_now(), 8'h98);
    bus.load_val = 8'h03; bus.load = 1'b1;
    step();
    check("midld_cnt",  count_now(), 8'h03);
    check("midld_busy", {7'd0, bus.busy}, 8'd0);
    check("midld_done", {7'd0, bus.done}, 8'd0);

    // Pause beats start in IDLE
    bus.load = 1'b0; bus.pause = 1'b1;
    step();
    check("pause_idle_busy", {7'd0, bus.busy}, 8'd0);
    check("pause_idle_cnt",  count_now(), 8'h03);
    bus.pause = 1'b0;

    // Full run from 99
    bus.load_val = 8'h99; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    check("full_entry_busy", {7'd0, bus.busy}, 8'd1);
    check("full_entry_cnt",  count_now(), 8'h99);
    for (int i = 1; i <= 99; i++) begin
      int r;
      step();
      r = 99 - i;
      exp_cnt = {4'(r / 10), 4'(r % 10)};
      check("full_cnt",  count_now(), exp_cnt);
      check("full_busy", {7'd0, bus.busy}, (i < 99) ? 8'd1 : 8'd0);
      check("full_done", {7'd0, bus.done}, (i < 99) ? 8'd0 : 8'd1);
    end
    step();
    check("full_nowrap", count_now(), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
